fetch_decode_seq: RTL and testbench

Sequencing stage directly upstream of bank_register. It fetches 16-bit instructions over a req/ack instruction-memory handshake at the PC supplied by the register bank. It decodes register-direct double-operand instructions, drives the source and destination selects, and starts the downstream ALU. It then writes the ALU result back through the bank write port and commits PC+2 through the bank's pc_inc path.

---
 rtl/fetch_decode_seq_if.sv | 22 ++
 rtl/fetch_decode_seq.sv | 131 +++++++++++++
 tb/tb_fetch_decode_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_seq_if.sv
// Instruction-memory req/ack bundle between the sequencer and imem.
// The sequencer is the master. Data is valid alongside ack.
interface fetch_decode_seq_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_decode_seq.sv
// Fetch/decode/writeback sequencer feeding bank_register and the ALU.
// Handles register-direct double-operand instructions only.
module fetch_decode_seq #(
  parameter int PC_STEP = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [15:0]        pc_in,
  fetch_decode_seq_if.master imem,
  output logic [3:0]         src_reg,
  output logic [3:0]         dst_reg,
  output logic [3:0]         alu_op,
  output logic               alu_bw,
  output logic               alu_start,
  input  logic               alu_done,
  input  logic [15:0]        alu_result,
  output logic [3:0]         wr_reg,
  output logic [15:0]        wr_data,
  output logic               wr_en,
  output logic [15:0]        pc_data_in,
  output logic               pc_inc,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPRD,
    EXEC,
    WBACK,
    PCINC,
    SETTLE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] ir;
  logic [15:0] addr_q;
  logic        exec_first;
  logic        settle_cnt;
  logic        legal;
  logic        wb_en;

  assign legal = (ir[15:14] != 2'b00)
               & (ir[5:4] == 2'b00)
               & ~ir[7]
               & (ir[3:0] != 4'd0);

  // CMP and BIT only set flags
  assign wb_en = (ir[15:12] != 4'd9)
               & (ir[15:12] != 4'd11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (run) nxt = FETCH;
      FETCH:  if (imem.imem_ack) nxt = DECODE;
      DECODE: nxt = legal ? OPRD : PCINC;
      OPRD:   nxt = EXEC;
      EXEC: begin
        if (alu_done)
          nxt = wb_en ? WBACK : PCINC;
      end
      WBACK:  nxt = PCINC;
      PCINC:  nxt = SETTLE;
      SETTLE: if (settle_cnt) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == FETCH);
    imem.imem_addr = addr_q;
    alu_start      = (state == EXEC) & exec_first;
    wr_en          = (state == WBACK);
    pc_inc         = (state == PCINC);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      ir         <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      alu_op     <= '0;
      alu_bw     <= 1'b0;
      exec_first <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
      pc_data_in <= '0;
      illegal    <= 1'b0;
      retired    <= '0;
      settle_cnt <= 1'b0;
    end else begin
      exec_first <= (state == OPRD);
      settle_cnt <= (state == SETTLE) & ~settle_cnt;
      if (state == IDLE && run)
        addr_q <= pc_in;
      // selects are valid throughout DECODE
      if (state == FETCH && imem.imem_ack) begin
        ir      <= imem.imem_data;
        alu_op  <= imem.imem_data[15:12];
        src_reg <= imem.imem_data[11:8];
        alu_bw  <= imem.imem_data[6];
        dst_reg <= imem.imem_data[3:0];
      end
      if (state == DECODE && !legal)
        illegal <= 1'b1;
      if (state == EXEC && alu_done) begin
        wr_data <= alu_result;
        wr_reg  <= ir[3:0];
      end
      if (nxt == PCINC)
        pc_data_in <= pc_in + 16'(PC_STEP);
      if (state == PCINC)
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq: vector table plus
// reset, back-to-back and ignored-handshake sequences.
module tb_fetch_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] pc_in;
  logic [3:0]  src_reg;
  logic [3:0]  dst_reg;
  logic [3:0]  alu_op;
  logic        alu_bw;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [15:0] pc_data_in;
  logic        pc_inc;
  logic        illegal;
  logic [15:0] retired;
  logic        busy;

  fetch_decode_seq_if imem ();

  fetch_decode_seq #(.PC_STEP(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .pc_in      (pc_in),
    .imem       (imem.master),
    .src_reg    (src_reg),
    .dst_reg    (dst_reg),
    .alu_op     (alu_op),
    .alu_bw     (alu_bw),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .pc_data_in (pc_data_in),
    .pc_inc     (pc_inc),
    .illegal    (illegal),
    .retired    (retired),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    int          ack_dly;
    int          done_dly;
    logic [15:0] res;
    bit          legal;
    bit          wb;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [3:0]  op;
    bit          bw;
    logic [15:0] npc;
    int          cyc;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int wrs = 0;
  int incs = 0;
  int overlap = 0;
  int cyc = 0;
  logic [3:0]  l_wr_reg;
  logic [15:0] l_wr_data;
  logic [15:0] l_pc;
  int exp_ret = 0;
  bit exp_ill = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (alu_start) starts++;
    if (wr_en) begin
      wrs++;
      l_wr_reg  = wr_reg;
      l_wr_data = wr_data;
    end
    if (pc_inc) begin
      incs++;
      l_pc = pc_data_in;
    end
    if (wr_en && pc_inc) overlap++;
  endtask

  task automatic do_instr(input vec_t v,
                          input bit keep_run,
                          input bit full);
    int n;
    int s0, w0, i0, c0;
    s0 = starts;
    w0 = wrs;
    i0 = incs;
    pc_in = v.pc;
    run = 1'b1;
    n = 0;
    while (!imem.imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(imem.imem_req), 32'd1);
    chk("imem_addr", 32'(imem.imem_addr), 32'(v.pc));
    c0 = cyc;
    if (!keep_run) run = 1'b0;
    for (int k = 0; k < v.ack_dly; k++) begin
      step();
      if (!imem.imem_req || imem.imem_addr !== v.pc)
        chk("req_hold", 32'(imem.imem_addr), 32'(v.pc));
    end
    imem.imem_ack  = 1'b1;
    imem.imem_data = v.instr;
    step();
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'hFFFF;
    if (full) begin
      chk("src_reg", 32'(src_reg), 32'(v.src));
      chk("dst_reg", 32'(dst_reg), 32'(v.dst));
      chk("alu_op", 32'(alu_op), 32'(v.op));
      chk("alu_bw", 32'(alu_bw), 32'(v.bw));
    end
    if (v.legal) begin
      n = 0;
      while (starts == s0 && n < 10) begin
        step();
        n++;
      end
      chk("start_seen", 32'(starts - s0), 32'd1);
      for (int k = 0; k < v.done_dly; k++) step();
      alu_done   = 1'b1;
      alu_result = v.res;
      step();
      alu_done   = 1'b0;
      alu_result = 16'hDEAD;
    end
    n = 0;
    while (incs == i0 && n < 20) begin
      step();
      n++;
    end
    step();
    exp_ret++;
    if (!v.legal) exp_ill = 1'b1;
    if (full) begin
      chk("starts", 32'(starts - s0), v.legal ? 32'd1 : 32'd0);
      chk("wr_count", 32'(wrs - w0), v.wb ? 32'd1 : 32'd0);
      chk("pc_count", 32'(incs - i0), 32'd1);
      chk("pc_data_in", 32'(l_pc), 32'(v.npc));
      chk("retired", 32'(retired), 32'(exp_ret));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      if (v.wb) begin
        chk("wr_reg", 32'(l_wr_reg), 32'(v.dst));
        chk("wr_data", 32'(l_wr_data), 32'(v.res));
      end
    end
    if (!keep_run) begin
      n = 0;
      while (busy && n < 30) begin
        step();
        n++;
      end
      chk("idle_again", 32'(busy), 32'd0);
      if (full && v.cyc > 0)
        chk("cycles", 32'(cyc - c0), 32'(v.cyc));
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_addr", 32'(imem.imem_addr), 32'd0);
    chk("rst_start", 32'(alu_start), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_src", 32'(src_reg), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_pc_data", 32'(pc_data_in), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
  endtask

  initial begin
    int w0, i0, r0;
    vec_t v;
    //        pc       instr    ack done res      lg wb src   dst   op    bw npc      cyc
    vecs[0] = '{16'h0010, 16'h5405, 3, 2, 16'h1C06, 1, 1, 4'h4, 4'h5, 4'h5, 0, 16'h0012, 13};
    vecs[1] = '{16'h0012, 16'h9405, 0, 0, 16'h0000, 1, 0, 4'h4, 4'h5, 4'h9, 0, 16'h0014, 7};
    vecs[2] = '{16'h0014, 16'h1285, 0, 0, 16'h0000, 0, 0, 4'h2, 4'h5, 4'h1, 0, 16'h0016, 5};
    vecs[3] = '{16'h0016, 16'h5425, 0, 0, 16'h0000, 0, 0, 4'h4, 4'h5, 4'h5, 0, 16'h0018, 5};
    vecs[4] = '{16'h0018, 16'h5400, 0, 0, 16'h0000, 0, 0, 4'h4, 4'h0, 4'h5, 0, 16'h001A, 5};
    vecs[5] = '{16'hFFFE, 16'h4A07, 0, 0, 16'hBEEF, 1, 1, 4'hA, 4'h7, 4'h4, 0, 16'h0000, 8};
    vecs[6] = '{16'h1000, 16'hB34C, 1, 1, 16'h0000, 1, 0, 4'h3, 4'hC, 4'hB, 1, 16'h1002, 9};
    vecs[7] = '{16'h2000, 16'h5485, 2, 0, 16'h0000, 0, 0, 4'h4, 4'h5, 4'h5, 0, 16'h2002, 7};

    rst = 1'b0;
    run = 1'b0;
    pc_in = 16'h0000;
    alu_done = 1'b0;
    alu_result = 16'hDEAD;
    imem.imem_ack = 1'b0;
    imem.imem_data = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) do_instr(vecs[i], 1'b0, 1'b1);

    // ack and done while idle must be ignored
    r0 = retired;
    imem.imem_ack = 1'b1;
    imem.imem_data = 16'h5405;
    alu_done = 1'b1;
    step();
    step();
    imem.imem_ack = 1'b0;
    alu_done = 1'b0;
    step();
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_ret", 32'(retired), 32'(r0));

    // four back-to-back ADDs, run dropped during the last one
    w0 = wrs;
    i0 = incs;
    r0 = retired;
    for (int i = 0; i < 4; i++) begin
      v = '{16'h0100 + 16'(2 * i), 16'h5405, 1, 3,
            16'h0A00 + 16'(i), 1, 1, 4'h4, 4'h5,
            4'h5, 0, 16'h0102 + 16'(2 * i), 0};
      do_instr(v, (i < 3), 1'b0);
      chk("b2b_wr_data", 32'(l_wr_data), 32'h0A00 + 32'(i));
    end
    chk("b2b_wr_count", 32'(wrs - w0), 32'd4);
    chk("b2b_pc_count", 32'(incs - i0), 32'd4);
    chk("b2b_retired", 32'(retired - r0), 32'd4);
    chk("b2b_last_pc", 32'(l_pc), 32'h0108);
    repeat (4) step();
    chk("b2b_halt_busy", 32'(busy), 32'd0);
    chk("b2b_halt_req", 32'(imem.imem_req), 32'd0);

    // reset while waiting in EXEC
    pc_in = 16'h0100;
    run = 1'b1;
    step();
    run = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_data = 16'h5405;
    step();
    imem.imem_ack = 1'b0;
    step();
    step();
    chk("exec_start", 32'(alu_start), 32'd1);
    step();
    chk("exec_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs();
    w0 = wrs;
    i0 = incs;
    step();
    rst = 1'b1;
    alu_done = 1'b1;
    alu_result = 16'h1234;
    step();
    alu_done = 1'b0;
    repeat (6) step();
    chk("post_rst_wr", 32'(wrs - w0), 32'd0);
    chk("post_rst_pc", 32'(incs - i0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wdata", 32'(wr_data), 32'd0);
    chk("wr_pc_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
